// File: rtl/wb_uart.sv
// Wishbone B4 classic slave UART: TX byte FIFO into an 8N1 serialiser, 8N1 deserialiser into a
// one-entry holding register, and a programmable clocks-per-bit divisor.
module wb_uart #(
  parameter int unsigned DIV_RESET = 434,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  input  logic [2:0]  CTI_O,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivMin = DIV_W'(2);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  // Cycle type, low address bits and upper data bits carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{CTI_O, ADR[31:4], ADR[1:0], DAT_I[31:DIV_W]};

  // ---------------------------------------------------------------------------------------------
  // Bus decode
  logic        ack_q, err_q;
  logic [31:0] dat_q, rd_mux;
  logic        req;
  logic [1:0]  sel;
  logic        wr_data, rd_data, wr_stat, wr_div;

  logic [DIV_W-1:0] div_q;
  logic             rx_valid_q, overrun_q, frame_err_q;
  logic [7:0]       rx_byte_q;
  logic             tx_empty, tx_full, tx_busy;

  // ACK/ERR gate the request so a held strobe terminates once per two cycles.
  assign req     = CYC & STB & ~ack_q & ~err_q;
  assign sel     = ADR[3:2];
  assign wr_data = req & WE & (sel == 2'd0);
  assign rd_data = req & ~WE & (sel == 2'd0);
  assign wr_stat = req & WE & (sel == 2'd1);
  assign wr_div  = req & WE & (sel == 2'd2);

  // Register read multiplexer
  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0:    rd_mux = {24'b0, rx_byte_q};
      2'd1:    rd_mux = {26'b0, frame_err_q, tx_busy, overrun_q, rx_valid_q, tx_empty, tx_full};
      2'd2:    rd_mux = 32'(div_q);
      default: rd_mux = '0;
    endcase
  end

  // Single-cycle termination and read data, registered one cycle after the request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req & (sel != 2'd3);
      err_q <= req & (sel == 2'd3);
      dat_q <= (req & ~WE & (sel != 2'd3)) ? rd_mux : '0;
    end
  end

  assign DAT_O = dat_q;
  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign RTY   = 1'b0;

  // Divisor register; anything below 2 would leave no room for a half-bit sample point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= DIV_W'(DIV_RESET);
    end else if (wr_div) begin
      div_q <= (DAT_I[DIV_W-1:0] < DivMin) ? DivMin : DAT_I[DIV_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // TX FIFO
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [TX_DEPTH];
  logic        tx_pop, tx_push;

  assign tx_empty = (wr_ptr_q == rd_ptr_q);
  assign tx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign tx_push  = wr_data & (~tx_full | tx_pop);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) mem_q[wr_ptr_q[AW-1:0]] <= DAT_I[7:0];
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (tx_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // TX serialiser
  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d, tx_end;

  assign tx_end  = (tx_cnt_q == tx_div_q - DivOne);
  assign tx_busy = (tx_state_q != TxIdle);

  // TX next state; a frame start pops the FIFO and latches the divisor for the whole frame
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q[AW-1:0]];
          tx_div_d   = div_q;
          tx_cnt_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + DivOne;
        end
      end
      TxData: begin
        if (tx_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
        end else begin
          tx_cnt_d = tx_cnt_q + DivOne;
        end
      end
      TxStop: begin
        if (tx_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = mem_q[rd_ptr_q[AW-1:0]];
            tx_div_d   = div_q;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + DivOne;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // Registered line level follows the next state so tx has no combinational path.
    case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(DIV_RESET);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------------------------------------
  // RX deserialiser
  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic             rx_land, rx_ferr, rx_end, rx_half;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_end  = (rx_cnt_q == rx_div_q - DivOne);
  assign rx_half = (rx_cnt_q == (rx_div_q >> 1));

  // RX next state; start is re-checked at half a bit, later samples land at bit centres
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_land    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_div_d   = div_q;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + DivOne;
        end
      end
      RxData: begin
        if (rx_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + DivOne;
        end
      end
      RxStop: begin
        if (rx_end) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_land    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_d = RxWait;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + DivOne;
        end
      end
      RxWait: begin
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(DIV_RESET);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Holding register and sticky error flags; a read coinciding with a landing byte is no overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_land) begin
        rx_valid_q <= 1'b1;
        if (!rx_valid_q || rd_data) rx_byte_q <= rx_shift_q;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_land && rx_valid_q && !rd_data) overrun_q <= 1'b1;
      else if (wr_stat && DAT_I[3])          overrun_q <= 1'b0;
      if (rx_ferr)                           frame_err_q <= 1'b1;
      else if (wr_stat && DAT_I[5])          frame_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed-sequence bench for wb_uart with randomized data checked against a frame-level model.
module tb_wb_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CYC = 1'b0, STB = 1'b0, WE = 1'b0;
  logic [31:0] ADR = '0, DAT_I = '0;
  logic [2:0]  CTI_O = '0;
  logic [31:0] DAT_O;
  logic        ACK, ERR, RTY, tx;
  logic        rx_drv = 1'b1, loop_en = 1'b0;
  logic        rx;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  wb_uart dut (
    .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .DAT_I(DAT_I),
    .CTI_O(CTI_O), .DAT_O(DAT_O), .ACK(ACK), .ERR(ERR), .RTY(RTY), .rx(rx), .tx(tx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Line monitor: decodes 8N1 frames from tx at the current bit period
  int         mdiv = 4;
  logic       mon_en = 1'b0;
  logic [7:0] mon_byte_q[$];
  logic       mon_stop_q[$];
  int         mon_t_q[$];

  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        t0 = cyc;
        repeat (mdiv / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (mdiv) @(negedge clk);
          b[i] = tx;
        end
        repeat (mdiv) @(negedge clk);
        mon_byte_q.push_back(b);
        mon_stop_q.push_back(tx);
        mon_t_q.push_back(t0);
      end
    end
  end

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                    output logic [31:0] rdat, output logic ack, output logic err);
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_I = wdat; CTI_O = 3'($urandom);
    @(negedge clk);
    rdat = DAT_O; ack = ACK; err = ERR;
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] d;
    logic a, e;
    wb(1'b1, adr, wdat, d, a, e);
    chk("wr_ack", {a, e}, 2'b10);
  endtask

  task automatic reg_rd(input logic [31:0] adr, output logic [31:0] d);
    logic a, e;
    wb(1'b0, adr, 32'h0, d, a, e);
    chk("rd_ack", {a, e}, 2'b10);
  endtask

  // Drive one 8N1 frame onto rx, each bit d cycles, then one idle bit time
  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (d) @(negedge clk);
    end
    rx_drv = stop;
    repeat (d) @(negedge clk);
    rx_drv = 1'b1;
    repeat (d) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mon_byte_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        a, e, ok;
    logic [39:0] obs, expv;
    logic [9:0]  frame;
    logic [7:0]  bytes[10];
    logic [7:0]  b0, b1, b2;
    logic [3:0]  acks;
    int          div_rand;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_bus", {ACK, ERR, RTY, DAT_O}, 35'h0);
    chk("reset_tx", tx, 1'b1);
    rst = 1'b1;
    reg_rd(32'h4, d);
    chk("status_after_reset", d, 32'h02);
    reg_rd(32'h8, d);
    chk("div_after_reset", d, 32'd434);

    // Reset in the middle of a frame
    reg_wr(32'h0, 32'h55);
    repeat (50) @(negedge clk);
    chk("tx_in_start_bit", tx, 1'b0);
    rst = 1'b0;
    #1;
    chk("tx_high_on_reset", tx, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    reg_rd(32'h4, d);
    chk("status_after_midframe_reset", d, 32'h02);
    reg_rd(32'h8, d);
    chk("div_after_midframe_reset", d, 32'd434);
    repeat (20) @(negedge clk);
    chk("tx_idle_after_reset", tx, 1'b1);

    // Divisor register
    div_rand = int'($urandom_range(65535, 2));
    reg_wr(32'h8, {16'($urandom), 16'(div_rand)});
    reg_rd(32'h8, d);
    chk("div_random", d, 32'(div_rand));
    reg_wr(32'h8, 32'hABCD_0001);
    reg_rd(32'h8, d);
    chk("div_clamp_1", d, 32'd2);
    reg_wr(32'h8, 32'h0);
    reg_rd(32'h8, d);
    chk("div_clamp_0", d, 32'd2);

    // Single frame waveform at DIV=4
    reg_wr(32'h8, 32'd4);
    mdiv = 4;
    mon_en = 1'b1;
    reg_wr(32'h0, 32'hA5);
    frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      obs[i]  = tx;
      expv[i] = frame[i / 4];
      @(negedge clk);
    end
    chk("a5_waveform", obs, expv);
    wait_frames(1, 100, ok);
    chk("a5_frame_seen", ok, 1'b1);
    if (ok) chk("a5_decoded", {mon_stop_q[0], mon_byte_q[0]}, {1'b1, 8'hA5});
    repeat (10) @(negedge clk);
    mon_byte_q.delete(); mon_stop_q.delete(); mon_t_q.delete();

    // Burst of 10 writes: first byte leaves at once, next 8 fill the FIFO, the 10th is dropped
    for (int k = 0; k < 10; k++) bytes[k] = 8'($urandom);
    for (int k = 0; k < 9; k++) reg_wr(32'h0, {24'($urandom), bytes[k]});
    reg_rd(32'h4, d);
    chk("status_full", d, 32'h11);
    reg_wr(32'h0, {24'h0, bytes[9]});
    wait_frames(9, 9 * 40 + 200, ok);
    chk("burst_frames_seen", ok, 1'b1);
    repeat (60) @(negedge clk);
    chk("burst_frame_count", mon_byte_q.size(), 9);
    if (ok) begin
      for (int k = 0; k < 9; k++) begin
        chk("burst_byte", {mon_stop_q[k], mon_byte_q[k]}, {1'b1, bytes[k]});
        if (k > 0) chk("burst_gap", mon_t_q[k] - mon_t_q[k-1], 40);
      end
    end
    reg_rd(32'h4, d);
    chk("status_drained", d, 32'h02);

    // Loopback at DIV=8 with random bytes
    reg_wr(32'h8, 32'd8);
    mdiv = 8;
    loop_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b0 = 8'($urandom);
      reg_wr(32'h0, {24'h0, b0});
      ok = 1'b0;
      for (int p = 0; p < 150; p++) begin
        reg_rd(32'h4, d);
        if (d[2]) begin
          ok = 1'b1;
          break;
        end
      end
      chk("loop_rx_valid", ok, 1'b1);
      reg_rd(32'h0, d);
      chk("loop_data", d, {24'h0, b0});
      reg_rd(32'h4, d);
      chk("loop_rx_valid_cleared", d[2], 1'b0);
      repeat (30) @(negedge clk);
    end
    loop_en = 1'b0;
    mon_en = 1'b0;

    // Overrun: two frames without a read keep the first byte
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    send_rx(b1, 1'b1, 8);
    send_rx(b2, 1'b1, 8);
    repeat (4) @(negedge clk);
    reg_rd(32'h4, d);
    chk("status_overrun", d, 32'h0E);
    reg_rd(32'h0, d);
    chk("overrun_keeps_first", d, {24'h0, b1});
    reg_wr(32'h4, 32'h08);
    reg_rd(32'h4, d);
    chk("overrun_cleared", d, 32'h02);

    // Framing error
    send_rx(8'($urandom), 1'b0, 8);
    repeat (4) @(negedge clk);
    reg_rd(32'h4, d);
    chk("status_frame_err", d, 32'h22);
    reg_rd(32'h0, d);
    chk("data_last_byte", d, {24'h0, b1});
    reg_wr(32'h4, 32'h20);
    reg_rd(32'h4, d);
    chk("frame_err_cleared", d, 32'h02);

    // Unmapped address terminates with ERR and has no side effect
    wb(1'b1, 32'h0000_000C, 32'h3, d, a, e);
    chk("unmapped_wr_term", {a, e}, 2'b01);
    @(negedge clk);
    chk("err_one_cycle", {ACK, ERR}, 2'b00);
    wb(1'b0, 32'hFFFF_FFFC, 32'h0, d, a, e);
    chk("unmapped_rd", {a, e, d}, {2'b01, 32'h0});
    reg_rd(32'hFFFF_FFF8, d);
    chk("div_unchanged_high_adr", d, 32'd8);

    // Held strobe sees one termination every two cycles
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h4;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      acks[i] = ACK;
    end
    CYC = 1'b0; STB = 1'b0;
    chk("held_stb_acks", acks, 4'b1010);
    @(negedge clk);
    chk("ack_drops", {ACK, DAT_O}, 33'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
